// File: rtl/knight_cmd_responder.sv
// knight_cmd_responder
//   Robot-side endpoint of the Bluetooth command link. Assembles two UART
//   bytes (high first) into a 16-bit command for cmd_proc, and sends one-byte
//   responses back through the UART transmitter.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   rx_rdy, rx_data   : byte available from UART_rx
//   clr_rx_rdy        : combinational consume strobe back to UART_rx
//   cmd, cmd_rdy      : assembled command and its valid flag
//   clr_cmd_rdy       : consumer acknowledge
//   frame_err         : pulse when a half command is discarded on timeout
//   send_resp, resp   : response request and byte
//   trmt, tx_data     : start strobe and byte for UART_tx
//   tx_done           : UART_tx finished the byte
//   resp_sent         : pulse per completed response byte
//   resp_ovr          : pulse when a response is dropped
module knight_cmd_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_sent,
  output logic        resp_ovr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {WAIT_HI, WAIT_LO} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  // ---------------- Rx path ----------------
  rx_state_t        rx_state, rx_state_nxt;
  logic [7:0]       hi_byte, hi_byte_nxt;
  logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
  logic [15:0]      cmd_nxt;
  logic             cmd_rdy_nxt;
  logic             frame_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= WAIT_HI;
      hi_byte   <= '0;
      to_cnt    <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_state_nxt;
      hi_byte   <= hi_byte_nxt;
      to_cnt    <= to_cnt_nxt;
      cmd       <= cmd_nxt;
      cmd_rdy   <= cmd_rdy_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    rx_state_nxt  = rx_state;
    hi_byte_nxt   = hi_byte;
    to_cnt_nxt    = to_cnt;
    cmd_nxt       = cmd;
    cmd_rdy_nxt   = cmd_rdy & ~clr_cmd_rdy;
    frame_err_nxt = 1'b0;
    clr_rx_rdy    = 1'b0;
    case (rx_state)
      WAIT_HI: begin
        if (rx_rdy) begin
          clr_rx_rdy   = ~rst;
          hi_byte_nxt  = rx_data;
          cmd_rdy_nxt  = 1'b0;  // new command supersedes an unconsumed one
          to_cnt_nxt   = '0;
          rx_state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          // a byte arriving on the last allowed idle cycle still completes the command
          clr_rx_rdy   = ~rst;
          cmd_nxt      = {hi_byte, rx_data};
          cmd_rdy_nxt  = 1'b1;  // set wins over a same-cycle clr_cmd_rdy
          rx_state_nxt = WAIT_HI;
        end else if (to_cnt == CNT_LAST) begin
          frame_err_nxt = 1'b1;
          hi_byte_nxt   = '0;
          to_cnt_nxt    = '0;
          rx_state_nxt  = WAIT_HI;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      default: rx_state_nxt = WAIT_HI;
    endcase
  end

  // ---------------- Tx path ----------------
  tx_state_t  tx_state, tx_state_nxt;
  logic       pend_vld, pend_vld_nxt;
  logic [7:0] pend_byte, pend_byte_nxt;
  logic [7:0] tx_data_nxt;
  logic       trmt_nxt, resp_sent_nxt, resp_ovr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      pend_vld  <= 1'b0;
      pend_byte <= '0;
      tx_data   <= '0;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      resp_ovr  <= 1'b0;
    end else begin
      tx_state  <= tx_state_nxt;
      pend_vld  <= pend_vld_nxt;
      pend_byte <= pend_byte_nxt;
      tx_data   <= tx_data_nxt;
      trmt      <= trmt_nxt;
      resp_sent <= resp_sent_nxt;
      resp_ovr  <= resp_ovr_nxt;
    end
  end

  always_comb begin
    tx_state_nxt  = tx_state;
    pend_vld_nxt  = pend_vld;
    pend_byte_nxt = pend_byte;
    tx_data_nxt   = tx_data;
    trmt_nxt      = 1'b0;
    resp_sent_nxt = 1'b0;
    resp_ovr_nxt  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        // tx_done is deliberately ignored here
        if (send_resp) begin
          tx_data_nxt  = resp;
          trmt_nxt     = 1'b1;
          tx_state_nxt = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          resp_sent_nxt = 1'b1;
          if (pend_vld) begin
            tx_data_nxt  = pend_byte;
            trmt_nxt     = 1'b1;
            // the slot frees this cycle, so a simultaneous request refills it
            pend_vld_nxt = send_resp;
            if (send_resp) pend_byte_nxt = resp;
          end else if (send_resp) begin
            tx_data_nxt = resp;
            trmt_nxt    = 1'b1;
          end else begin
            tx_state_nxt = TX_IDLE;
          end
        end else if (send_resp) begin
          if (!pend_vld) begin
            pend_vld_nxt  = 1'b1;
            pend_byte_nxt = resp;
          end else begin
            resp_ovr_nxt = 1'b1;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_knight_cmd_responder.sv
module tb_knight_cmd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        frame_err;
  logic        send_resp;
  logic [7:0]  resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_sent;
  logic        resp_ovr;

  int tests = 0;
  int fails = 0;
  int fe_cnt;
  int fe_idx;

  always #5 clk = ~clk;

  knight_cmd_responder #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .frame_err(frame_err),
    .send_resp(send_resp), .resp(resp),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .resp_sent(resp_sent), .resp_ovr(resp_ovr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one byte for a single sample edge; leaves time at edge+1.
  task automatic send_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    #1;
    chk("clr_rx_rdy_hi", {15'd0, clr_rx_rdy}, 16'd1);
    tick();
    rx_rdy = 1'b0;
    #1;
    chk("clr_rx_rdy_lo", {15'd0, clr_rx_rdy}, 16'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd"}, cmd, 16'h0000);
    chk({tag, "_cmd_rdy"}, {15'd0, cmd_rdy}, 16'd0);
    chk({tag, "_frame_err"}, {15'd0, frame_err}, 16'd0);
    chk({tag, "_trmt"}, {15'd0, trmt}, 16'd0);
    chk({tag, "_tx_data"}, {8'd0, tx_data}, 16'h0000);
    chk({tag, "_resp_sent"}, {15'd0, resp_sent}, 16'd0);
    chk({tag, "_resp_ovr"}, {15'd0, resp_ovr}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; resp = 8'h00; tx_done = 1'b0;
    tick(); tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Basic two-byte command, bytes 10 cycles apart
    send_byte(8'h2D);
    repeat (9) tick();
    chk("no_rdy_after_hi", {15'd0, cmd_rdy}, 16'd0);
    send_byte(8'h34);
    chk("cmd_2d34", cmd, 16'h2D34);
    chk("cmd_rdy_set", {15'd0, cmd_rdy}, 16'd1);
    repeat (3) tick();
    chk("cmd_rdy_held", {15'd0, cmd_rdy}, 16'd1);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk("cmd_rdy_cleared", {15'd0, cmd_rdy}, 16'd0);
    chk("cmd_kept", cmd, 16'h2D34);

    // New command supersedes an unconsumed one
    send_byte(8'h2D);
    send_byte(8'h34);
    chk("rdy_before_supersede", {15'd0, cmd_rdy}, 16'd1);
    send_byte(8'h4F);
    chk("supersede_rdy_drop", {15'd0, cmd_rdy}, 16'd0);
    chk("supersede_cmd_hold", cmd, 16'h2D34);
    send_byte(8'h01);
    chk("cmd_4f01", cmd, 16'h4F01);
    chk("cmd_rdy_4f01", {15'd0, cmd_rdy}, 16'd1);

    // Set wins over same-cycle clear
    send_byte(8'h12);
    clr_cmd_rdy = 1'b1;
    send_byte(8'h34);
    clr_cmd_rdy = 1'b0;
    chk("set_wins_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("set_wins_cmd", cmd, 16'h1234);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;

    // Timeout: frame_err on the 100th idle sample after the high byte
    send_byte(8'h40);
    fe_cnt = 0; fe_idx = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (frame_err) begin fe_cnt++; fe_idx = i; end
    end
    tick();
    if (frame_err) fe_cnt++;
    chk("frame_err_count", fe_cnt[15:0], 16'd1);
    chk("frame_err_when", fe_idx[15:0], 16'd100);
    chk("timeout_cmd_hold", cmd, 16'h1234);
    chk("timeout_rdy_hold", {15'd0, cmd_rdy}, 16'd0);
    send_byte(8'h60);
    send_byte(8'h00);
    chk("cmd_6000", cmd, 16'h6000);

    // Low byte on the last allowed idle cycle still completes
    send_byte(8'h77);
    fe_cnt = 0;
    for (int i = 1; i <= 99; i++) begin
      tick();
      if (frame_err) fe_cnt++;
    end
    send_byte(8'h88);
    tick();
    if (frame_err) fe_cnt++;
    chk("edge_no_frame_err", fe_cnt[15:0], 16'd0);
    chk("cmd_7788", cmd, 16'h7788);
    chk("cmd_rdy_7788", {15'd0, cmd_rdy}, 16'd1);

    // Single response
    send_resp = 1'b1; resp = 8'hA5; tick(); send_resp = 1'b0;
    chk("trmt_a5", {15'd0, trmt}, 16'd1);
    chk("tx_data_a5", {8'd0, tx_data}, 16'h00A5);
    tick();
    chk("trmt_one_cycle", {15'd0, trmt}, 16'd0);
    repeat (28) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("resp_sent_a5", {15'd0, resp_sent}, 16'd1);
    chk("no_trmt_after_done", {15'd0, trmt}, 16'd0);
    tick();
    chk("resp_sent_pulse", {15'd0, resp_sent}, 16'd0);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("idle_ignores_done", {15'd0, resp_sent}, 16'd0);

    // Queue one, overrun the next
    send_resp = 1'b1; resp = 8'hA5; tick();
    resp = 8'h5A; tick();
    chk("queue_no_ovr", {15'd0, resp_ovr}, 16'd0);
    resp = 8'h11; tick(); send_resp = 1'b0;
    chk("ovr_pulse", {15'd0, resp_ovr}, 16'd1);
    chk("busy_tx_data", {8'd0, tx_data}, 16'h00A5);
    tick();
    chk("ovr_one_cycle", {15'd0, resp_ovr}, 16'd0);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("pend_resp_sent", {15'd0, resp_sent}, 16'd1);
    chk("pend_trmt", {15'd0, trmt}, 16'd1);
    chk("pend_tx_data", {8'd0, tx_data}, 16'h005A);
    repeat (3) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("last_resp_sent", {15'd0, resp_sent}, 16'd1);
    chk("dropped_not_sent", {15'd0, trmt}, 16'd0);

    // Same-cycle tx_done and send_resp with empty buffer
    tick();
    send_resp = 1'b1; resp = 8'hC3; tick(); send_resp = 1'b0;
    repeat (3) tick();
    tx_done = 1'b1; send_resp = 1'b1; resp = 8'h3C; tick();
    tx_done = 1'b0; send_resp = 1'b0;
    chk("same_cycle_sent", {15'd0, resp_sent}, 16'd1);
    chk("same_cycle_trmt", {15'd0, trmt}, 16'd1);
    chk("same_cycle_data", {8'd0, tx_data}, 16'h003C);
    chk("same_cycle_no_ovr", {15'd0, resp_ovr}, 16'd0);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("same_cycle_done", {15'd0, trmt}, 16'd0);

    // Reset mid-command and mid-transmission
    send_resp = 1'b1; resp = 8'h99; tick();
    resp = 8'h66; tick(); send_resp = 1'b0;
    send_byte(8'h2D);
    rst = 1'b1; tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("rst_done_ignored", {15'd0, resp_sent}, 16'd0);
    chk("rst_pend_dropped", {15'd0, trmt}, 16'd0);
    send_byte(8'h34);
    repeat (3) tick();
    chk("rst_34_is_hi", {15'd0, cmd_rdy}, 16'd0);
    send_byte(8'h56);
    chk("cmd_3456", cmd, 16'h3456);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/knight_cmd_responder.md
# knight_cmd_responder

Robot-side endpoint of the Bluetooth command link. Assembles two received UART bytes (high byte first) into a 16-bit command for `cmd_proc` and holds it with a ready flag until consumed. Transmits one-byte responses (positive ack 8'hA5, move-done 8'h5A) back to the remote. Sits between `UART_rx`/`UART_tx` and `cmd_proc` inside `KnightsTour`.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle clocks allowed between the high and low byte of one command.
- `clk  in  1`: system clock; all logic is rising-edge.
- `rst  in  1`: synchronous, active-high reset.
- `rx_rdy  in  1`: UART receiver holds a byte.
- `rx_data  in  8`: received byte; valid while `rx_rdy`.
- `clr_rx_rdy  out  1`: combinational; high in the cycle a byte is consumed.
- `cmd  out  16`: assembled command, {high, low}.
- `cmd_rdy  out  1`: `cmd` valid and not yet consumed.
- `clr_cmd_rdy  in  1`: consumer acknowledges `cmd`.
- `frame_err  out  1`: one-cycle pulse when a partial command is discarded on timeout.
- `send_resp  in  1`: one-cycle request to transmit `resp`.
- `resp  in  8`: response byte; sampled when `send_resp` is high.
- `trmt  out  1`: one-cycle pulse starting a UART transmission.
- `tx_data  out  8`: byte for the UART transmitter; stable from `trmt` until `tx_done`.
- `tx_done  in  1`: UART transmitter has finished the byte.
- `resp_sent  out  1`: one-cycle pulse when `tx_done` is seen for an issued byte.
- `resp_ovr  out  1`: one-cycle pulse when a response is dropped.

## Operation
- Rx FSM states: `WAIT_HI`, `WAIT_LO`. Reset state is `WAIT_HI`.
- `WAIT_HI` with `rx_rdy`:
  - Capture `rx_data` into the high register.
  - Assert `clr_rx_rdy`.
  - Clear `cmd_rdy` if set; a new command supersedes an unconsumed one.
  - Clear the timeout counter and go to `WAIT_LO`.
- `WAIT_LO` with `rx_rdy`:
  - Capture the low byte and assert `clr_rx_rdy`.
  - Load `cmd` = {high, low}, set `cmd_rdy`, go to `WAIT_HI`.
- `WAIT_LO` without `rx_rdy`:
  - Increment the timeout counter.
  - At count `TIMEOUT_CYCLES-1`: pulse `frame_err`, discard the high byte, go to `WAIT_HI`. `cmd` and `cmd_rdy` are unchanged.
  - Counter width is `$clog2(TIMEOUT_CYCLES)`.
- `cmd_rdy` clears on `clr_cmd_rdy`.
  - If `clr_cmd_rdy` and a low-byte capture occur in the same cycle, set wins.
  - `cmd` holds its value after clear.
- Tx FSM states: `TX_IDLE`, `TX_BUSY`, plus a one-entry pending buffer (`pend_vld`, `pend_byte`).
- `TX_IDLE` with `send_resp`: load `tx_data` = `resp`, pulse `trmt` next cycle, go to `TX_BUSY`.
- `TX_BUSY` with `send_resp`:
  - If `pend_vld` is 0: store the byte in the pending buffer.
  - Otherwise: drop the new byte and pulse `resp_ovr`.
- `TX_BUSY` with `tx_done`:
  - Pulse `resp_sent`.
  - If pending: `tx_data` = `pend_byte`, pulse `trmt` next cycle, clear `pend_vld`, stay in `TX_BUSY`.
  - Otherwise: go to `TX_IDLE`.
- Same cycle `tx_done` and `send_resp` with `pend_vld`=0: the new byte becomes the next transmission; no overrun.
- Rx and Tx paths are independent; simultaneous activity on both is legal.

## Timing
- Reset values:
  - `cmd`=16'h0000, `cmd_rdy`=0.
  - `frame_err`=0, `trmt`=0, `tx_data`=8'h00.
  - `resp_sent`=0, `resp_ovr`=0.
  - `pend_vld`=0, timeout counter=0.
  - Both FSMs at their idle states.
- Reset mid-command discards the partial byte. Reset mid-transmission drops the pending byte; a later `tx_done` in `TX_IDLE` is ignored.
- `clr_rx_rdy` is asserted in the same cycle `rx_rdy` is sampled high. The receiver must drop `rx_rdy` by the next edge.
- `cmd_rdy` rises on the edge after the low byte is sampled.
- `trmt` is high exactly one cycle, on the edge after the `send_resp` sample (or after the `tx_done` sample when a pending byte is issued).
- `resp_sent`, `frame_err` and `resp_ovr` are registered, one-cycle pulses.
- `tx_done` is ignored in `TX_IDLE`.

## Test plan
- Bytes 8'h2D, then 8'h34, 10 cycles apart -> `clr_rx_rdy` pulses twice; `cmd`=16'h2D34; `cmd_rdy`=1 until `clr_cmd_rdy`, then 0 with `cmd` still 16'h2D34.
- `TIMEOUT_CYCLES`=100: byte 8'h40, then nothing for 100 cycles -> `frame_err` pulses once; next pair 8'h60/8'h00 yields `cmd`=16'h6000.
- `cmd_rdy`=1 with `cmd`=16'h2D34, new byte 8'h4F arrives unconsumed -> `cmd_rdy` drops in the capture cycle; after byte 8'h01, `cmd`=16'h4F01.
- `send_resp` with `resp`=8'hA5 -> `trmt` one cycle later, `tx_data`=8'hA5; `tx_done` after 30 cycles -> `resp_sent` pulse, FSM returns to `TX_IDLE`.
- While busy sending 8'hA5: `send_resp` 8'h5A, then `send_resp` 8'h11 -> 8'h5A is queued, `resp_ovr` pulses for 8'h11; after `tx_done`, `trmt` fires with `tx_data`=8'h5A.
- `rst` asserted for 1 cycle between byte 8'h2D and byte 8'h34 -> no `cmd_rdy`; 8'h34 is treated as a high byte; all outputs at reset values after the `rst` edge.
